// File: rtl/unidad_de_control_param.sv
// Multicycle control unit for the CISC datapath: fetch, decode, ALU, load/store, jump/branch,
// memory-ready wait with timeout, and a HALT state carrying a sticky error flag.

module unidad_de_control_param #(
    parameter int ANCHO_INSTR = 16,
    parameter int ANCHO_DIR   = 3,
    parameter int ANCHO_FUN   = 4,
    parameter int ESPERA_MAX  = 15
) (
    input  logic                   Reloj,
    input  logic                   Reiniciar,
    input  logic [ANCHO_INSTR-1:0] Instruccion,
    input  logic                   StatusFlag,
    input  logic                   MemListo,
    input  logic                   Continuar,
    output logic                   CargaPC,
    output logic                   CargaIR,
    output logic                   CargaAR,
    output logic                   CargaStatus,
    output logic [1:0]             SelPC,
    output logic                   MemLee,
    output logic                   MemEscribe,
    output logic                   SelDir,
    output logic                   EscribeReg,
    output logic                   SelEscritura,
    output logic [ANCHO_DIR-1:0]   WriteAddress,
    output logic [ANCHO_DIR-1:0]   ReadAddressA,
    output logic [ANCHO_DIR-1:0]   ReadAddressB,
    output logic [ANCHO_FUN-1:0]   Fun,
    output logic                   Detenido,
    output logic                   Error
);

    localparam int POS_A = ANCHO_DIR;
    localparam int POS_D = 2 * ANCHO_DIR;
    localparam int POS_F = 3 * ANCHO_DIR;
    localparam int CNT_W = (ESPERA_MAX > 0) ? $clog2(ESPERA_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ULT = CNT_W'((ESPERA_MAX > 0) ? ESPERA_MAX - 1 : 0);

    typedef enum logic [3:0] {
        FETCH,
        CARGA_IR,
        DECODE,
        EJEC_ALU,
        DIR_MEM,
        ESPERA_MEM,
        ESCRIBE_MEM_REG,
        SALTO,
        HALT
    } estado_t;

    typedef enum logic [2:0] {
        C_ALU0   = 3'b000,
        C_ALU1   = 3'b001,
        C_LOAD   = 3'b010,
        C_STORE  = 3'b011,
        C_JUMP   = 3'b100,
        C_BRANCH = 3'b101,
        C_HALT   = 3'b110,
        C_ILEGAL = 3'b111
    } clase_t;

    estado_t              estado_q, estado_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 error_q, error_d;

    logic [ANCHO_DIR-1:0] campo_a, campo_b, campo_d;
    logic [ANCHO_FUN-1:0] campo_f;
    clase_t               clase;
    logic                 espera_vencida;
    logic                 salto_tomado;

    assign campo_b = Instruccion[ANCHO_DIR-1:0];
    assign campo_a = Instruccion[POS_A +: ANCHO_DIR];
    assign campo_d = Instruccion[POS_D +: ANCHO_DIR];
    assign campo_f = Instruccion[POS_F +: ANCHO_FUN];
    assign clase   = clase_t'(Instruccion[ANCHO_INSTR-1 -: 3]);

    // The wait that would bring the counter up to ESPERA_MAX is the last one allowed;
    // a MemListo arriving on that same cycle still wins.
    assign espera_vencida = (ESPERA_MAX != 0) && !MemListo && (cnt_q == CNT_ULT);
    assign salto_tomado   = (clase == C_JUMP) || (StatusFlag == campo_f[0]);

    always_ff @(posedge Reloj or negedge Reiniciar) begin
        if (!Reiniciar) begin
            estado_q <= FETCH;
            cnt_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        cnt_d        = '0;
        error_d      = error_q;
        CargaPC      = 1'b0;
        CargaIR      = 1'b0;
        CargaAR      = 1'b0;
        CargaStatus  = 1'b0;
        SelPC        = 2'b00;
        MemLee       = 1'b0;
        MemEscribe   = 1'b0;
        SelDir       = 1'b0;
        EscribeReg   = 1'b0;
        SelEscritura = 1'b0;
        WriteAddress = '0;
        ReadAddressA = '0;
        ReadAddressB = '0;
        Fun          = '0;
        Detenido     = 1'b0;
        Error        = error_q;

        case (estado_q)
            FETCH: begin
                MemLee = 1'b1;
                if (MemListo) begin
                    estado_d = CARGA_IR;
                end else if (espera_vencida) begin
                    estado_d = HALT;
                    error_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CARGA_IR: begin
                CargaIR  = 1'b1;
                CargaPC  = 1'b1;
                SelPC    = 2'b01;
                estado_d = DECODE;
            end
            DECODE: begin
                case (clase)
                    C_ALU0, C_ALU1:   estado_d = EJEC_ALU;
                    C_LOAD, C_STORE:  estado_d = DIR_MEM;
                    C_JUMP, C_BRANCH: estado_d = SALTO;
                    C_HALT:           estado_d = HALT;
                    default: begin
                        estado_d = HALT;
                        error_d  = 1'b1;
                    end
                endcase
            end
            EJEC_ALU: begin
                Fun          = campo_f;
                WriteAddress = campo_d;
                ReadAddressA = campo_a;
                ReadAddressB = campo_b;
                EscribeReg   = 1'b1;
                CargaStatus  = 1'b1;
                estado_d     = FETCH;
            end
            DIR_MEM: begin
                ReadAddressA = campo_a;
                Fun          = '1;
                CargaAR      = 1'b1;
                estado_d     = ESPERA_MEM;
            end
            ESPERA_MEM: begin
                SelDir = 1'b1;
                if (clase == C_STORE) begin
                    MemEscribe   = 1'b1;
                    ReadAddressB = campo_b;
                end else begin
                    MemLee = 1'b1;
                end
                if (MemListo) begin
                    estado_d = (clase == C_STORE) ? FETCH : ESCRIBE_MEM_REG;
                end else if (espera_vencida) begin
                    estado_d = HALT;
                    error_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ESCRIBE_MEM_REG: begin
                EscribeReg   = 1'b1;
                SelEscritura = 1'b1;
                WriteAddress = campo_d;
                estado_d     = FETCH;
            end
            SALTO: begin
                ReadAddressA = campo_a;
                if (salto_tomado) begin
                    CargaPC = 1'b1;
                    SelPC   = 2'b10;
                end
                estado_d = FETCH;
            end
            HALT: begin
                Detenido = 1'b1;
                if (Continuar && !error_q) begin
                    estado_d = FETCH;
                end
            end
            default: estado_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_unidad_de_control_param.sv
// Bench for unidad_de_control_param: per-instruction expected output traces are generated from
// the instruction-level rules and replayed cycle by cycle against the unit.

module tb_unidad_de_control_param;

    localparam int ESPERA = 15;

    logic        Reloj;
    logic        Reiniciar;
    logic [15:0] Instruccion;
    logic        StatusFlag, MemListo, Continuar;
    logic        CargaPC, CargaIR, CargaAR, CargaStatus;
    logic [1:0]  SelPC;
    logic        MemLee, MemEscribe, SelDir, EscribeReg, SelEscritura;
    logic [2:0]  WriteAddress, ReadAddressA, ReadAddressB;
    logic [3:0]  Fun;
    logic        Detenido, Error;

    typedef struct packed {
        logic       carga_pc, carga_ir, carga_ar, carga_st;
        logic [1:0] sel_pc;
        logic       mem_lee, mem_esc, sel_dir, esc_reg, sel_esc;
        logic [2:0] wa, ra, rb;
        logic [3:0] fun;
        logic       det, err;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [15:0] ins;
        logic        ml, sf, cont;
        outs_t       exp;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic err_m  = 1'b0;
    logic pend_rst = 1'b0;

    unidad_de_control_param #(
        .ANCHO_INSTR(16),
        .ANCHO_DIR  (3),
        .ANCHO_FUN  (4),
        .ESPERA_MAX (ESPERA)
    ) dut (
        .Reloj       (Reloj),
        .Reiniciar   (Reiniciar),
        .Instruccion (Instruccion),
        .StatusFlag  (StatusFlag),
        .MemListo    (MemListo),
        .Continuar   (Continuar),
        .CargaPC     (CargaPC),
        .CargaIR     (CargaIR),
        .CargaAR     (CargaAR),
        .CargaStatus (CargaStatus),
        .SelPC       (SelPC),
        .MemLee      (MemLee),
        .MemEscribe  (MemEscribe),
        .SelDir      (SelDir),
        .EscribeReg  (EscribeReg),
        .SelEscritura(SelEscritura),
        .WriteAddress(WriteAddress),
        .ReadAddressA(ReadAddressA),
        .ReadAddressB(ReadAddressB),
        .Fun         (Fun),
        .Detenido    (Detenido),
        .Error       (Error)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t sample();
        return {CargaPC, CargaIR, CargaAR, CargaStatus, SelPC, MemLee, MemEscribe, SelDir,
                EscribeReg, SelEscritura, WriteAddress, ReadAddressA, ReadAddressB, Fun,
                Detenido, Error};
    endfunction

    function automatic outs_t fetch_outs();
        outs_t e = '0;
        e.mem_lee = 1'b1;
        return e;
    endfunction

    task automatic push(input logic [15:0] ins, input logic ml, input logic sf,
                        input logic cont, input outs_t e);
        ent_t t;
        t.rst  = pend_rst;
        t.ins  = ins;
        t.ml   = ml;
        t.sf   = sf;
        t.cont = cont;
        t.exp  = e;
        pend_rst = 1'b0;
        q.push_back(t);
    endtask

    task automatic model_reset();
        pend_rst = 1'b1;
        err_m    = 1'b0;
    endtask

    // Expected trace of one instruction: fw/mw are MemListo-low cycles in fetch / memory wait,
    // sf is StatusFlag during the branch cycle, hk is how long HALT is held before Continuar.
    task automatic model_instr(input logic [15:0] ins, input int fw, input int mw,
                               input logic sf, input int hk);
        logic [2:0] c, d, a, b;
        logic [3:0] f;
        outs_t      e;
        c = ins[15:13];
        f = ins[12:9];
        d = ins[8:6];
        a = ins[5:3];
        b = ins[2:0];
        for (int i = 0; i < ((fw < ESPERA) ? fw : ESPERA); i++)
            push(ins, 1'b0, rbit(), 1'b0, fetch_outs());
        if (fw >= ESPERA) begin
            err_m = 1'b1;
            e = '0; e.det = 1'b1; e.err = 1'b1;
            push(ins, rbit(), rbit(), 1'b0, e);
            return;
        end
        push(ins, 1'b1, rbit(), 1'b0, fetch_outs());
        e = '0; e.carga_ir = 1'b1; e.carga_pc = 1'b1; e.sel_pc = 2'b01;
        push(ins, rbit(), rbit(), 1'b0, e);
        e = '0;
        push(ins, rbit(), rbit(), 1'b0, e);
        case (c)
            3'd0, 3'd1: begin
                e = '0; e.fun = f; e.wa = d; e.ra = a; e.rb = b; e.esc_reg = 1'b1; e.carga_st = 1'b1;
                push(ins, rbit(), rbit(), 1'b0, e);
            end
            3'd2, 3'd3: begin
                e = '0; e.ra = a; e.fun = 4'hF; e.carga_ar = 1'b1;
                push(ins, rbit(), rbit(), 1'b0, e);
                e = '0; e.sel_dir = 1'b1;
                if (c == 3'd2) e.mem_lee = 1'b1;
                else begin e.mem_esc = 1'b1; e.rb = b; end
                for (int i = 0; i < ((mw < ESPERA) ? mw : ESPERA); i++)
                    push(ins, 1'b0, rbit(), 1'b0, e);
                if (mw >= ESPERA) begin
                    err_m = 1'b1;
                    e = '0; e.det = 1'b1; e.err = 1'b1;
                    push(ins, rbit(), rbit(), 1'b0, e);
                    return;
                end
                push(ins, 1'b1, rbit(), 1'b0, e);
                if (c == 3'd2) begin
                    e = '0; e.esc_reg = 1'b1; e.sel_esc = 1'b1; e.wa = d;
                    push(ins, rbit(), rbit(), 1'b0, e);
                end
            end
            3'd4, 3'd5: begin
                e = '0; e.ra = a;
                if (c == 3'd4 || sf == f[0]) begin e.carga_pc = 1'b1; e.sel_pc = 2'b10; end
                push(ins, rbit(), sf, 1'b0, e);
            end
            3'd6: begin
                e = '0; e.det = 1'b1; e.err = err_m;
                for (int i = 0; i < hk; i++) push(ins, rbit(), rbit(), 1'b0, e);
                push(ins, rbit(), rbit(), 1'b1, e);
            end
            default: begin
                err_m = 1'b1;
                e = '0; e.det = 1'b1; e.err = 1'b1;
                for (int i = 0; i <= hk; i++) push(ins, rbit(), rbit(), rbit(), e);
            end
        endcase
    endtask

    // Drives one cycle's inputs on the falling edge (optionally after a reset pulse) and samples.
    task automatic step(input ent_t t, output outs_t act);
        @(negedge Reloj);
        if (t.rst) begin
            Reiniciar = 1'b0;
            #2;
            Reiniciar = 1'b1;
        end
        Instruccion = t.ins;
        MemListo    = t.ml;
        StatusFlag  = t.sf;
        Continuar   = t.cont;
        #1;
        act = sample();
    endtask

    function automatic logic [15:0] rand_instr(input logic [2:0] c);
        logic [15:0] w;
        w = 16'($urandom);
        w[15:13] = c;
        return w;
    endfunction

    task automatic test_reset();
        outs_t act;
        Reiniciar = 1'b0; MemListo = 1'b1; Continuar = 1'b1; StatusFlag = 1'b0; Instruccion = '0;
        #2;
        act = sample();
        checks++;
        if (act !== fetch_outs()) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", act, fetch_outs());
        end
        @(posedge Reloj); #1;
        act = sample();
        checks++;
        if (act !== fetch_outs()) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", act, fetch_outs());
        end
        MemListo = 1'b0; Continuar = 1'b0;
        @(posedge Reloj); #1;
        Reiniciar = 1'b1;
        err_m = 1'b0;
    endtask

    task automatic test_alu_fixed();
        outs_t act;
        q.delete();
        model_instr(16'h0A53, 0, 0, 1'b0, 0);
        model_instr(16'h0A53, 2, 0, 1'b0, 0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], act);
            checks++;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL alu_0a53 cycle %0d: got %h expected %h", i, act, q[i].exp);
            end
        end
    endtask

    task automatic test_load_wait();
        outs_t act;
        q.delete();
        model_instr(16'h4128, 0, 3, 1'b0, 0);
        model_instr({3'b011, 4'h0, 3'd1, 3'd7, 3'd5}, 1, 2, 1'b0, 0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], act);
            checks++;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL load_store_wait cycle %0d: got %h expected %h", i, act, q[i].exp);
            end
        end
    endtask

    task automatic test_branch();
        outs_t act;
        q.delete();
        model_instr({3'b101, 4'b0001, 3'd0, 3'd4, 3'd0}, 0, 0, 1'b1, 0);
        model_instr({3'b101, 4'b0001, 3'd0, 3'd4, 3'd0}, 0, 0, 1'b0, 0);
        model_instr({3'b101, 4'b0110, 3'd2, 3'd6, 3'd1}, 0, 0, 1'b0, 0);
        model_instr({3'b101, 4'b0110, 3'd2, 3'd6, 3'd1}, 0, 0, 1'b1, 0);
        model_instr({3'b100, 4'b0000, 3'd0, 3'd3, 3'd0}, 1, 0, 1'b0, 0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], act);
            checks++;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL branch_jump cycle %0d: got %h expected %h", i, act, q[i].exp);
            end
        end
    endtask

    task automatic test_halt();
        outs_t act;
        q.delete();
        model_instr({3'b110, 13'h0}, 0, 0, 1'b0, 2);
        model_instr(rand_instr(3'd0), 0, 0, 1'b0, 0);
        model_instr(rand_instr(3'd7), 0, 0, 1'b0, 4);
        model_reset();
        model_instr(rand_instr(3'd1), 0, 0, 1'b0, 0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], act);
            checks++;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL halt_illegal cycle %0d: got %h expected %h", i, act, q[i].exp);
            end
        end
    endtask

    task automatic test_timeout();
        outs_t act;
        outs_t e;
        q.delete();
        model_instr(rand_instr(3'd0), 20, 0, 1'b0, 0);
        e = '0; e.det = 1'b1; e.err = 1'b1;
        for (int i = 0; i < 3; i++) push(16'h0, rbit(), rbit(), 1'b1, e);
        model_reset();
        model_instr(rand_instr(3'd2), 0, 15, 1'b0, 0);
        model_reset();
        model_instr(rand_instr(3'd3), 0, 16, 1'b0, 0);
        model_reset();
        model_instr(rand_instr(3'd2), 14, 14, 1'b0, 0);
        model_instr(rand_instr(3'd3), 0, 14, 1'b0, 0);
        model_instr(rand_instr(3'd0), 14, 0, 1'b0, 0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], act);
            checks++;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL timeout cycle %0d: got %h expected %h", i, act, q[i].exp);
            end
        end
    endtask

    task automatic test_random();
        outs_t act;
        logic [2:0] c;
        int fw, mw;
        q.delete();
        for (int n = 0; n < 60; n++) begin
            c  = 3'($urandom_range(0, 6));
            fw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
            model_instr(rand_instr(c), fw, mw, rbit(), int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], act);
            checks++;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL random_stream cycle %0d: got %h expected %h", i, act, q[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        outs_t act;
        q.delete();
        model_instr({3'b011, 4'h0, 3'd0, 3'd2, 3'd6}, 0, 5, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            step(q[i], act);
            checks++;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL store_before_reset cycle %0d: got %h expected %h", i, act, q[i].exp);
            end
        end
        #2;
        Reiniciar = 1'b0;
        #1;
        act = sample();
        checks++;
        if (act !== fetch_outs()) begin
            errors++;
            $display("FAIL reset_mid_store: got %h expected %h", act, fetch_outs());
        end
        @(posedge Reloj); #1;
        Reiniciar = 1'b1;
        err_m = 1'b0;
        q.delete();
        model_instr(rand_instr(3'd0), 1, 0, 1'b0, 0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i], act);
            checks++;
            if (act !== q[i].exp) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got %h expected %h", i, act, q[i].exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_fixed();
        test_load_wait();
        test_branch();
        test_halt();
        test_timeout();
        test_random();
        test_reset_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
